// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: width codes, FSM states,
// owner encodings, reset polarity and a byte-count helper.
package mem_arbiter_pkg;

    // Reset is asserted when rst equals this value.
    localparam logic RST_ENABLE = 1'b0;

    // Access width codes on mem_width_i (2'b11 behaves as a word).
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Which requester currently owns the RAM port.
    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    // Number of bytes moved for a given width code.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: byte_count = 3'd1;
            WIDTH_HALF: byte_count = 3'd2;
            default:    byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-facing and RAM-facing signals of the memory arbiter.
//
// Handshake: a requester raises its *_req_i with stable request fields and
// keeps it up until its *_done_o pulse (one cycle, qualified by rdy). The
// arbiter samples requests only in IDLE; deasserting a request mid-transfer
// has no effect, and the requester must drop or change its request in the
// cycle it sees done so the same access is not re-issued. RAM read data on
// ram_din_i is expected one cycle after its address on ram_a_o.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [31:0]       if_inst_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [1:0]        mem_width_i;
    logic              mem_sext_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_done_o;
    logic [31:0]       mem_rdata_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;
    logic              stall_req_o;

    // Pipeline stages plus RAM model side.
    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_width_i, mem_sext_i, mem_wdata_i,
        output ram_din_i,
        input  if_done_o, if_inst_o, mem_done_o, mem_rdata_o,
        input  ram_a_o, ram_dout_o, ram_wr_o, stall_req_o
    );

    // The arbiter itself.
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_width_i, mem_sext_i, mem_wdata_i,
        input  ram_din_i,
        output if_done_o, if_inst_o, mem_done_o, mem_rdata_o,
        output ram_a_o, ram_dout_o, ram_wr_o, stall_req_o
    );
endinterface

// File: rtl/mem_arb_assembler.sv
// Read-data assembler: bytes shift in from the top, so after N captures the
// transfer sits little-endian in the upper N bytes; extension is combinational.
module mem_arb_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        capture,
    input  logic [7:0]  din,
    input  logic [1:0]  width,
    input  logic        sext,
    output logic [31:0] word,
    output logic [31:0] ext
);

    logic [31:0] data;

    // Byte-lane shift register: clear at transfer start/abort, shift on capture.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (capture) begin
            data <= {din, data[31:8]};
        end
    end

    // Full word for fetches; byte/half taken from the top lanes and extended.
    always_comb begin
        word = data;
        case (width)
            WIDTH_BYTE: ext = {{24{sext & data[31]}}, data[31:24]};
            WIDTH_HALF: ext = {{16{sext & data[31]}}, data[31:16]};
            default:    ext = data;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// moving one byte per cycle and raising the pipeline stall request.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus,
    output logic [1:0]   state_dbg
);

    logic [1:0]  state;
    logic        owner;
    logic [31:0] base;
    logic        we;
    logic [1:0]  width;
    logic        sext;
    logic [31:0] wdata;
    logic [2:0]  n_bytes;
    logic [2:0]  idx;

    logic        in_reset;
    logic        flush_abort;
    logic        capture;
    logic        clear;
    logic        driving;
    logic        mem_done;
    logic [31:0] addr_cur;

    assign in_reset    = (rst == RST_ENABLE);
    // A flush only matters while the fetch owns the port.
    assign flush_abort = (owner == OWNER_IF) && bus.if_flush_i &&
                         ((state == ST_RUN) || (state == ST_DONE));
    assign capture     = rdy && !in_reset && (state == ST_RUN) && !we &&
                         (idx != 3'd0) && !flush_abort;
    assign clear       = rdy && !in_reset &&
                         (((state == ST_IDLE) && (bus.mem_req_i || bus.if_req_i)) || flush_abort);
    assign state_dbg   = state;

    // FSM, request latching and byte index; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state   <= ST_IDLE;
            owner   <= OWNER_IF;
            base    <= '0;
            we      <= 1'b0;
            width   <= WIDTH_BYTE;
            sext    <= 1'b0;
            wdata   <= '0;
            n_bytes <= '0;
            idx     <= '0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (bus.mem_req_i) begin
                        owner   <= OWNER_MEM;
                        base    <= bus.mem_addr_i;
                        we      <= bus.mem_we_i;
                        width   <= bus.mem_width_i;
                        sext    <= bus.mem_sext_i;
                        wdata   <= bus.mem_wdata_i;
                        n_bytes <= byte_count(bus.mem_width_i);
                        state   <= ST_RUN;
                    end else if (bus.if_req_i) begin
                        owner   <= OWNER_IF;
                        base    <= bus.if_addr_i;
                        we      <= 1'b0;
                        width   <= WIDTH_WORD;
                        sext    <= 1'b0;
                        wdata   <= '0;
                        n_bytes <= 3'd4;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_abort) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else if (we ? (idx == n_bytes - 3'd1) : (idx == n_bytes)) begin
                        // Writes finish on the last byte; reads need one extra
                        // cycle to capture the last byte returned by the RAM.
                        state <= ST_DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM drive, done pulses and stall request.
    always_comb begin
        addr_cur        = base + {29'd0, idx};
        driving         = (state == ST_RUN) && (idx < n_bytes);
        bus.ram_a_o     = driving ? ADDR_W'(addr_cur) : '0;
        bus.ram_wr_o    = rdy && !in_reset && (state == ST_RUN) && we;
        bus.ram_dout_o  = 8'd0;
        if ((state == ST_RUN) && we) begin
            case (idx[1:0])
                2'd0:    bus.ram_dout_o = wdata[7:0];
                2'd1:    bus.ram_dout_o = wdata[15:8];
                2'd2:    bus.ram_dout_o = wdata[23:16];
                default: bus.ram_dout_o = wdata[31:24];
            endcase
        end
        mem_done        = rdy && !in_reset && (state == ST_DONE) && (owner == OWNER_MEM);
        bus.mem_done_o  = mem_done;
        bus.if_done_o   = rdy && !in_reset && (state == ST_DONE) && (owner == OWNER_IF) &&
                          !bus.if_flush_i;
        bus.stall_req_o = (bus.mem_req_i && !mem_done) ||
                          ((state == ST_RUN) && (owner == OWNER_MEM));
    end

    mem_arb_assembler u_assembler (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .capture (capture),
        .din     (bus.ram_din_i),
        .width   (width),
        .sext    (sext),
        .word    (bus.if_inst_o),
        .ext     (bus.mem_rdata_o)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and per-cycle checks.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       rdy;
    logic [1:0] state_dbg;

    int tests;
    int fails;

    logic [7:0] ram  [0:1023];
    logic [7:0] wmem [0:1023];
    int wr_cnt;
    int ifd_cnt;
    int memd_cnt;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data one cycle after address; writes logged separately.
    initial begin
        wr_cnt   = 0;
        ifd_cnt  = 0;
        memd_cnt = 0;
    end
    always @(posedge clk) begin
        bus.ram_din_i <= ram[bus.ram_a_o[9:0]];
        if (bus.ram_wr_o === 1'b1) begin
            wmem[bus.ram_a_o[9:0]] <= bus.ram_dout_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.if_done_o === 1'b1)  ifd_cnt  <= ifd_cnt + 1;
        if (bus.mem_done_o === 1'b1) memd_cnt <= memd_cnt + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = 32'd0;
        bus.if_flush_i  = 1'b0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = 32'd0;
        bus.mem_width_i = 2'b00;
        bus.mem_sext_i  = 1'b0;
        bus.mem_wdata_i = 32'd0;
    endtask

    task automatic mem_issue(input logic we, input logic [31:0] addr, input logic [1:0] width,
                             input logic sext, input logic [31:0] wdata);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_addr_i  = addr;
        bus.mem_width_i = width;
        bus.mem_sext_i  = sext;
        bus.mem_wdata_i = wdata;
    endtask

    initial begin
        int base_wr;
        int base_ifd;
        int mem_cyc;
        int if_cyc;
        int mem_seen;
        int if_seen;
        logic [31:0] if_word;
        logic [31:0] mem_word;

        tests = 0;
        fails = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h104] = 8'hAA; ram[10'h105] = 8'hBB; ram[10'h106] = 8'hCC; ram[10'h107] = 8'hDD;
        ram[10'h007] = 8'h80;
        ram[10'h3FF] = 8'h34;
        ram[10'h000] = 8'h92;

        // Reset.
        rst = 1'b0;
        rdy = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_ram_a", bus.ram_a_o, 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr_o), 32'd0);
        check("rst_ram_dout", 32'(bus.ram_dout_o), 32'd0);
        check("rst_mem_done", 32'(bus.mem_done_o), 32'd0);
        check("rst_if_done", 32'(bus.if_done_o), 32'd0);
        check("rst_rdata", bus.mem_rdata_o, 32'd0);
        check("rst_inst", bus.if_inst_o, 32'd0);
        check("rst_stall", 32'(bus.stall_req_o), 32'd0);
        rst = 1'b1;
        tick();

        // Word load at 0x100: addresses T1..T4, done T6.
        mem_issue(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wl_ram_a", bus.ram_a_o, 32'h100 + 32'(k));
            check("wl_ram_wr", 32'(bus.ram_wr_o), 32'd0);
            check("wl_stall", 32'(bus.stall_req_o), 32'd1);
        end
        tick();
        check("wl_t5_ram_a", bus.ram_a_o, 32'd0);
        check("wl_t5_done", 32'(bus.mem_done_o), 32'd0);
        tick();
        check("wl_t6_done", 32'(bus.mem_done_o), 32'd1);
        check("wl_rdata", bus.mem_rdata_o, 32'h44332211);
        check("wl_t6_stall", 32'(bus.stall_req_o), 32'd0);
        bus.mem_req_i = 1'b0;
        tick();
        check("wl_t7_idle", 32'(state_dbg), 32'd0);
        check("wl_t7_done", 32'(bus.mem_done_o), 32'd0);

        // Byte load 0x80 at 0x7, sign- then zero-extended; done T3.
        for (int s = 1; s >= 0; s--) begin
            mem_issue(1'b0, 32'h7, 2'b00, 1'(s), 32'd0);
            tick();
            check("bl_ram_a", bus.ram_a_o, 32'h7);
            tick();
            check("bl_t2_done", 32'(bus.mem_done_o), 32'd0);
            tick();
            check("bl_t3_done", 32'(bus.mem_done_o), 32'd1);
            check("bl_rdata", bus.mem_rdata_o, (s == 1) ? 32'hFFFFFF80 : 32'h00000080);
            bus.mem_req_i = 1'b0;
            tick();
        end

        // Misaligned half load wrapping past 0xFFFFFFFF, sign-extended; done T4.
        mem_issue(1'b0, 32'hFFFFFFFF, 2'b01, 1'b1, 32'd0);
        tick();
        check("wrap_t1_a", bus.ram_a_o, 32'hFFFFFFFF);
        tick();
        check("wrap_t2_a", bus.ram_a_o, 32'h00000000);
        tick();
        check("wrap_t3_done", 32'(bus.mem_done_o), 32'd0);
        tick();
        check("wrap_t4_done", 32'(bus.mem_done_o), 32'd1);
        check("wrap_rdata", bus.mem_rdata_o, 32'hFFFF9234);
        bus.mem_req_i = 1'b0;
        tick();

        // Half store 0xBEEF at 0x20: two writes, done T3.
        base_wr = wr_cnt;
        mem_issue(1'b1, 32'h20, 2'b01, 1'b0, 32'h1234BEEF);
        #1;
        check("hs_t0_stall", 32'(bus.stall_req_o), 32'd1);
        tick();
        check("hs_t1_wr", 32'(bus.ram_wr_o), 32'd1);
        check("hs_t1_a", bus.ram_a_o, 32'h20);
        check("hs_t1_dout", 32'(bus.ram_dout_o), 32'hEF);
        check("hs_t1_stall", 32'(bus.stall_req_o), 32'd1);
        tick();
        check("hs_t2_wr", 32'(bus.ram_wr_o), 32'd1);
        check("hs_t2_a", bus.ram_a_o, 32'h21);
        check("hs_t2_dout", 32'(bus.ram_dout_o), 32'hBE);
        check("hs_t2_stall", 32'(bus.stall_req_o), 32'd1);
        tick();
        check("hs_t3_done", 32'(bus.mem_done_o), 32'd1);
        check("hs_t3_wr", 32'(bus.ram_wr_o), 32'd0);
        check("hs_t3_stall", 32'(bus.stall_req_o), 32'd0);
        bus.mem_req_i = 1'b0;
        tick();
        check("hs_byte0", 32'(wmem[10'h20]), 32'hEF);
        check("hs_byte1", 32'(wmem[10'h21]), 32'hBE);
        check("hs_wr_count", 32'(wr_cnt - base_wr), 32'd2);

        // Simultaneous IF and MEM requests: MEM first (done T3), IF done T10.
        mem_issue(1'b0, 32'h7, 2'b00, 1'b0, 32'd0);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        mem_cyc  = -1;
        if_cyc   = -1;
        mem_seen = 0;
        if_seen  = 0;
        if_word  = 32'd0;
        mem_word = 32'd0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.mem_done_o === 1'b1) begin
                mem_seen++;
                mem_cyc  = c;
                mem_word = bus.mem_rdata_o;
                bus.mem_req_i = 1'b0;
            end
            if (bus.if_done_o === 1'b1) begin
                if_seen++;
                if_cyc  = c;
                if_word = bus.if_inst_o;
                bus.if_req_i = 1'b0;
            end
        end
        check("tie_mem_cycle", 32'(mem_cyc), 32'd3);
        check("tie_if_cycle", 32'(if_cyc), 32'd10);
        check("tie_mem_once", 32'(mem_seen), 32'd1);
        check("tie_if_once", 32'(if_seen), 32'd1);
        check("tie_mem_rdata", mem_word, 32'h00000080);
        check("tie_if_inst", if_word, 32'h44332211);

        // Flush in the 3rd RUN cycle of a fetch, then a clean fetch at 0x104.
        base_ifd = ifd_cnt;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        tick();
        tick();
        tick();
        bus.if_flush_i = 1'b1;
        bus.if_req_i   = 1'b0;
        #1;
        check("fl_t3_ifdone", 32'(bus.if_done_o), 32'd0);
        tick();
        check("fl_t4_idle", 32'(state_dbg), 32'd0);
        check("fl_t4_ifdone", 32'(bus.if_done_o), 32'd0);
        check("fl_t4_inst", bus.if_inst_o, 32'd0);
        bus.if_flush_i = 1'b0;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h104;
        for (int c = 0; c < 5; c++) tick();
        check("fl_t9_ifdone", 32'(bus.if_done_o), 32'd0);
        tick();
        check("fl_t10_ifdone", 32'(bus.if_done_o), 32'd1);
        check("fl_inst", bus.if_inst_o, 32'hDDCCBBAA);
        bus.if_req_i = 1'b0;
        tick();
        check("fl_ifdone_count", 32'(ifd_cnt - base_ifd), 32'd1);

        // Word store with rdy low for 3 cycles: done moves from T5 to T8.
        base_wr = wr_cnt;
        mem_issue(1'b1, 32'h200, 2'b10, 1'b0, 32'hA1B2C3D4);
        tick();
        check("rdy_t1_a", bus.ram_a_o, 32'h200);
        check("rdy_t1_dout", 32'(bus.ram_dout_o), 32'hD4);
        tick();
        check("rdy_t2_a", bus.ram_a_o, 32'h201);
        check("rdy_t2_dout", 32'(bus.ram_dout_o), 32'hC3);
        tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rdy_low_wr", 32'(bus.ram_wr_o), 32'd0);
            check("rdy_low_done", 32'(bus.mem_done_o), 32'd0);
            tick();
        end
        rdy = 1'b1;
        #1;
        check("rdy_t6_wr", 32'(bus.ram_wr_o), 32'd1);
        check("rdy_t6_a", bus.ram_a_o, 32'h202);
        check("rdy_t6_dout", 32'(bus.ram_dout_o), 32'hB2);
        tick();
        check("rdy_t7_a", bus.ram_a_o, 32'h203);
        check("rdy_t7_dout", 32'(bus.ram_dout_o), 32'hA1);
        tick();
        check("rdy_t8_done", 32'(bus.mem_done_o), 32'd1);
        bus.mem_req_i = 1'b0;
        tick();
        check("rdy_wr_count", 32'(wr_cnt - base_wr), 32'd4);
        check("rdy_mem_word", {wmem[10'h203], wmem[10'h202], wmem[10'h201], wmem[10'h200]},
              32'hA1B2C3D4);

        // Reset in the middle of a word load.
        mem_issue(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        bus.mem_req_i = 1'b0;
        tick();
        check("rl_state", 32'(state_dbg), 32'd0);
        check("rl_ram_a", bus.ram_a_o, 32'd0);
        check("rl_ram_wr", 32'(bus.ram_wr_o), 32'd0);
        check("rl_done", 32'(bus.mem_done_o), 32'd0);
        check("rl_rdata", bus.mem_rdata_o, 32'd0);
        check("rl_inst", bus.if_inst_o, 32'd0);
        check("rl_stall", 32'(bus.stall_req_o), 32'd0);
        rst = 1'b1;
        tick();

        // Reset in the middle of a word store: only the first byte lands.
        base_wr = wr_cnt;
        mem_issue(1'b1, 32'h300, 2'b10, 1'b0, 32'h55667788);
        tick();
        check("rs_t1_wr", 32'(bus.ram_wr_o), 32'd1);
        tick();
        rst = 1'b0;
        bus.mem_req_i = 1'b0;
        #1;
        check("rs_t2_wr", 32'(bus.ram_wr_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("rs_wr_count", 32'(wr_cnt - base_wr), 32'd1);
        check("rs_idle", 32'(state_dbg), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
